// File: rtl/tap_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tap_controller
//  Purpose  : IEEE 1149.1 TAP state machine with DR/IR chain enables,
//             hold decode, a 1-bit bypass register and a registered TDO.
//  Ports    : TCK                 test clock (all state on rising edge)
//             rst                 synchronous active-high reset
//             TMS, TDI            test mode select / serial data in
//             inst[1:0]           current instruction
//             ir_tdo, dr_tdo      serial outputs of the IR / DR chains
//             clockdr/shiftdr/updatedr   DR-chain enables (Moore)
//             clockir/shiftir/updateir   IR-chain enables (Moore)
//             hold                scan data selected onto system outputs
//             tlr                 high in Test-Logic-Reset
//             TDO, tdo_en         registered serial out and its enable
//  Revision : 1.0  initial release
// ============================================================================
module tap_controller #(
    parameter logic [1:0] BYPASS_INST = 2'b11,
    parameter logic [1:0] EXTEST_INST = 2'b00,
    parameter logic [1:0] INTEST_INST = 2'b10
) (
    input  logic       TCK,
    input  logic       rst,
    input  logic       TMS,
    input  logic       TDI,
    input  logic [1:0] inst,
    input  logic       ir_tdo,
    input  logic       dr_tdo,
    output logic       clockdr,
    output logic       shiftdr,
    output logic       updatedr,
    output logic       clockir,
    output logic       shiftir,
    output logic       updateir,
    output logic       hold,
    output logic       tlr,
    output logic       TDO,
    output logic       tdo_en
);

    // State codes follow the encoding shown in IEEE 1149.1 figures.
    localparam logic [3:0] c_TLR   = 4'hF;
    localparam logic [3:0] c_RTI   = 4'hC;
    localparam logic [3:0] c_SELDR = 4'h7;
    localparam logic [3:0] c_CAPDR = 4'h6;
    localparam logic [3:0] c_SHDR  = 4'h2;
    localparam logic [3:0] c_EX1DR = 4'h1;
    localparam logic [3:0] c_PAUDR = 4'h3;
    localparam logic [3:0] c_EX2DR = 4'h0;
    localparam logic [3:0] c_UPDDR = 4'h5;
    localparam logic [3:0] c_SELIR = 4'h4;
    localparam logic [3:0] c_CAPIR = 4'hE;
    localparam logic [3:0] c_SHIR  = 4'hA;
    localparam logic [3:0] c_EX1IR = 4'h9;
    localparam logic [3:0] c_PAUIR = 4'hB;
    localparam logic [3:0] c_EX2IR = 4'h8;
    localparam logic [3:0] c_UPDIR = 4'hD;

    logic [3:0] state_q, state_d;
    logic       bypass_q, bypass_d;
    logic       tdo_q, tdo_d;
    logic       tdo_en_q, tdo_en_d;
    logic       w_is_bypass;

    assign w_is_bypass = (inst == BYPASS_INST);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge TCK) begin
        if (rst) begin
            state_q  <= c_TLR;
            bypass_q <= 1'b0;
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bypass_q <= bypass_d;
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_TLR:   state_d = TMS ? c_TLR   : c_RTI;
            c_RTI:   state_d = TMS ? c_SELDR : c_RTI;
            c_SELDR: state_d = TMS ? c_SELIR : c_CAPDR;
            c_CAPDR: state_d = TMS ? c_EX1DR : c_SHDR;
            c_SHDR:  state_d = TMS ? c_EX1DR : c_SHDR;
            c_EX1DR: state_d = TMS ? c_UPDDR : c_PAUDR;
            c_PAUDR: state_d = TMS ? c_EX2DR : c_PAUDR;
            c_EX2DR: state_d = TMS ? c_UPDDR : c_SHDR;
            c_UPDDR: state_d = TMS ? c_SELDR : c_RTI;
            c_SELIR: state_d = TMS ? c_TLR   : c_CAPIR;
            c_CAPIR: state_d = TMS ? c_EX1IR : c_SHIR;
            c_SHIR:  state_d = TMS ? c_EX1IR : c_SHIR;
            c_EX1IR: state_d = TMS ? c_UPDIR : c_PAUIR;
            c_PAUIR: state_d = TMS ? c_EX2IR : c_PAUIR;
            c_EX2IR: state_d = TMS ? c_UPDIR : c_SHIR;
            c_UPDIR: state_d = TMS ? c_SELDR : c_RTI;
            default: state_d = c_TLR;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values: bypass bit, TDO and its enable
    // ------------------------------------------------------------------
    always_comb begin
        bypass_d = bypass_q;
        if (w_is_bypass) begin
            if (state_q == c_CAPDR) begin
                bypass_d = 1'b0;
            end else if (state_q == c_SHDR) begin
                bypass_d = TDI;
            end
        end

        tdo_d = tdo_q;
        if (state_q == c_SHIR) begin
            tdo_d = ir_tdo;
        end else if (state_q == c_SHDR) begin
            // Bypass uses the value held before this edge's shift.
            tdo_d = w_is_bypass ? bypass_q : dr_tdo;
        end

        tdo_en_d = (state_q == c_SHDR) || (state_q == c_SHIR);
    end

    // ------------------------------------------------------------------
    // Moore output decode (state register only; hold also looks at inst)
    // ------------------------------------------------------------------
    always_comb begin
        clockdr  = (state_q == c_CAPDR) || (state_q == c_SHDR);
        shiftdr  = (state_q == c_SHDR);
        updatedr = (state_q == c_UPDDR);
        clockir  = (state_q == c_CAPIR) || (state_q == c_SHIR);
        shiftir  = (state_q == c_SHIR);
        updateir = (state_q == c_UPDIR);
        tlr      = (state_q == c_TLR);
        hold     = ((inst == EXTEST_INST) || (inst == INTEST_INST)) &&
                   (state_q != c_TLR);
        TDO      = tdo_q;
        tdo_en   = tdo_en_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_tap_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tap_controller
//  Purpose  : Self-checking bench for tap_controller: directed vector table,
//             combinational hold checks, randomized run against a table-based
//             reference model, and five-TMS=1 recovery from random states.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tap_controller;

    logic       TCK = 1'b0;
    logic       rst = 1'b1;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic [1:0] inst = 2'b01;
    logic       ir_tdo = 1'b0;
    logic       dr_tdo = 1'b0;
    logic       clockdr, shiftdr, updatedr, clockir, shiftir, updateir;
    logic       hold, tlr, TDO, tdo_en;

    tap_controller dut (
        .TCK(TCK), .rst(rst), .TMS(TMS), .TDI(TDI), .inst(inst),
        .ir_tdo(ir_tdo), .dr_tdo(dr_tdo),
        .clockdr(clockdr), .shiftdr(shiftdr), .updatedr(updatedr),
        .clockir(clockir), .shiftir(shiftir), .updateir(updateir),
        .hold(hold), .tlr(tlr), .TDO(TDO), .tdo_en(tdo_en)
    );

    always #5 TCK = ~TCK;

    // Observed outputs: {cdr,sdr,udr,cir,sir,uir,hold,tlr,TDO,tdo_en}
    logic [9:0] outs;
    assign outs = {clockdr, shiftdr, updatedr, clockir, shiftir, updateir,
                   hold, tlr, TDO, tdo_en};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: state index 0..15 in the order
    // TLR RTI SelDR CapDR ShDR Ex1DR PauDR Ex2DR UpdDR
    // SelIR CapIR ShIR Ex1IR PauIR Ex2IR UpdIR
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int   m_state = 0;
    logic m_byp = 1'b0;
    logic m_tdo = 1'b0;
    logic m_en  = 1'b0;

    typedef struct {
        logic       rst;
        logic       tms;
        logic       tdi;
        logic [1:0] inst;
        logic       ir;
        logic       dr;
        logic [9:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [9:0] act,
                         input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [9:0] model_outs();
        int s;
        logic h;
        s = m_state;
        h = ((inst == 2'b00) || (inst == 2'b10)) && (s != 0);
        return {(s == 3 || s == 4), (s == 4), (s == 8),
                (s == 10 || s == 11), (s == 11), (s == 15),
                h, (s == 0), m_tdo, m_en};
    endfunction

    // Drive one cycle of inputs, advance one rising edge, update the model.
    task automatic tick(input logic t_rst, input logic t_tms,
                        input logic t_tdi, input logic [1:0] t_inst,
                        input logic t_ir, input logic t_dr);
        int s;
        rst = t_rst; TMS = t_tms; TDI = t_tdi; inst = t_inst;
        ir_tdo = t_ir; dr_tdo = t_dr;
        @(posedge TCK);
        #1;
        s = m_state;
        if (t_rst) begin
            m_state = 0; m_byp = 1'b0; m_tdo = 1'b0; m_en = 1'b0;
        end else begin
            m_en = (s == 4) || (s == 11);
            if (s == 11)      m_tdo = t_ir;
            else if (s == 4)  m_tdo = (t_inst == 2'b11) ? m_byp : t_dr;
            if (t_inst == 2'b11) begin
                if (s == 3)      m_byp = 1'b0;
                else if (s == 4) m_byp = t_tdi;
            end
            m_state = t_tms ? nxt1[s] : nxt0[s];
        end
    endtask

    task automatic add(input logic r, input logic t, input logic d,
                       input logic [1:0] i, input logic ir, input logic dr,
                       input logic [9:0] e);
        vec_t v;
        v.rst = r; v.tms = t; v.tdi = d; v.inst = i; v.ir = ir; v.dr = dr;
        v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        // rst tms tdi inst ir dr expected
        add(1, 1, 0, 2'b01, 0, 0, 10'b0000000100); // reset -> TLR
        add(0, 0, 0, 2'b01, 0, 0, 10'b0000000000); // RTI
        add(0, 1, 0, 2'b01, 0, 0, 10'b0000000000); // SelDR
        add(0, 0, 0, 2'b01, 0, 0, 10'b1000000000); // CapDR
        add(0, 0, 0, 2'b01, 0, 0, 10'b1100000000); // ShDR
        add(0, 1, 0, 2'b01, 0, 1, 10'b0000000011); // Ex1DR, TDO=dr_tdo
        add(0, 1, 0, 2'b01, 0, 0, 10'b0010000010); // UpdDR
        add(0, 0, 0, 2'b01, 0, 0, 10'b0000000010); // RTI
        add(0, 1, 0, 2'b01, 0, 0, 10'b0000000010); // SelDR
        add(0, 1, 0, 2'b01, 0, 0, 10'b0000000010); // SelIR
        add(0, 0, 0, 2'b01, 0, 0, 10'b0001000010); // CapIR
        add(0, 0, 0, 2'b01, 0, 0, 10'b0001100010); // ShIR
        add(0, 0, 0, 2'b01, 1, 0, 10'b0001100011); // ShIR TDO=1
        add(0, 0, 0, 2'b01, 0, 0, 10'b0001100001); // ShIR TDO=0
        add(0, 0, 0, 2'b01, 1, 0, 10'b0001100011); // ShIR TDO=1
        add(0, 1, 0, 2'b01, 0, 0, 10'b0000000001); // Ex1IR
        add(0, 0, 0, 2'b01, 0, 0, 10'b0000000000); // PauIR
        add(0, 1, 0, 2'b00, 0, 0, 10'b0000001000); // Ex2IR, hold
        add(0, 1, 0, 2'b00, 0, 0, 10'b0000011000); // UpdIR
        add(0, 1, 0, 2'b00, 0, 0, 10'b0000001000); // SelDR
        add(0, 1, 0, 2'b00, 0, 0, 10'b0000001000); // SelIR
        add(0, 1, 0, 2'b00, 0, 0, 10'b0000000100); // TLR, hold=0
        add(0, 0, 0, 2'b11, 0, 0, 10'b0000000000); // RTI
        add(0, 1, 0, 2'b11, 0, 0, 10'b0000000000); // SelDR
        add(0, 0, 0, 2'b11, 0, 0, 10'b1000000000); // CapDR
        add(0, 0, 0, 2'b11, 0, 0, 10'b1100000000); // ShDR, bypass=0
        add(0, 0, 1, 2'b11, 0, 1, 10'b1100000001); // TDO=0 (captured)
        add(0, 0, 0, 2'b11, 0, 1, 10'b1100000011); // TDO=1
        add(0, 0, 1, 2'b11, 0, 0, 10'b1100000001); // TDO=0
        add(0, 0, 1, 2'b11, 0, 0, 10'b1100000011); // TDO=1
        add(1, 0, 0, 2'b11, 0, 0, 10'b0000000100); // rst mid-shift
        add(0, 0, 0, 2'b00, 0, 0, 10'b0000001000); // RTI hold=1
        add(0, 0, 0, 2'b01, 0, 0, 10'b0000000000); // RTI hold=0

        foreach (vecs[k]) begin
            tick(vecs[k].rst, vecs[k].tms, vecs[k].tdi, vecs[k].inst,
                 vecs[k].ir, vecs[k].dr);
            check($sformatf("vec%0d", k), outs, vecs[k].exp);
        end

        // hold follows inst within the same cycle (state is RTI here)
        inst = 2'b10; #1;
        check("hold_comb_intest", outs, 10'b0000001000);
        inst = 2'b01; #1;
        check("hold_comb_off", outs, 10'b0000000000);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            tick(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
                 2'($urandom), 1'($urandom), 1'($urandom));
            check("rand", outs, model_outs());
        end

        // Five TMS=1 from assorted reachable states always land in TLR
        for (int r = 0; r < 16; r++) begin
            for (int w = 0; w < int'($urandom_range(1, 7)); w++) begin
                tick(1'b0, 1'($urandom), 1'($urandom), 2'($urandom),
                     1'($urandom), 1'($urandom));
                check("walk", outs, model_outs());
            end
            for (int f = 0; f < 5; f++) begin
                tick(1'b0, 1'b1, 1'($urandom), 2'($urandom), 1'($urandom),
                     1'($urandom));
            end
            check("five_ones_tlr", {9'b0, tlr}, 10'd1);
            check("five_ones_model", outs, model_outs());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
